pcie_tx_req_arb: RTL and testbench
==================================

# pcie_tx_req_arb

Request arbiter and sequencer for the PCIe TX path. It collects the completion, memory-read (three channels) and memory-write (two channels) transmit requests and qualifies each against its flow-control grant. It selects one winner at a time, acknowledges that requester, and launches the shared TX TLP engine. It then holds the selection until the engine reports completion, and sits between the requester blocks and the TX engine.

## Interface
- CPLD_BURST_MAX, 4: maximum consecutive completion wins while any MRd/MWr is eligible; range 1..7.
- pcie_user_clk  in  1  user clock; all logic on rising edge.
- pcie_user_rst  in  1  reset, asynchronous, active-high.
- tx_cpld_gnt / tx_mrd_gnt / tx_mwr_gnt  in  1 each  flow-control grant per TLP class.
- tx_cpld_req, tx_mrd0_req, tx_mrd1_req, tx_mrd2_req, tx_mwr0_req, tx_mwr1_req  in  1 each  level request, held until own ack.
- tx_cpld_req_ack, tx_mrd0_req_ack … tx_mwr1_req_ack  out  1 each  one-cycle ack pulse to the winner.
- eng_sel  out  6  one-hot winner to TX engine; bit order {mwr1,mwr0,mrd2,mrd1,mrd0,cpld}.
- eng_start  out  1  one-cycle launch pulse.
- eng_done  in  1  one-cycle pulse: engine finished current TLP.
- arb_busy  out  1  high from launch until done.
- arb_proto_err  out  1  sticky: eng_done received outside BUSY.

## Operation
- Eligibility:
  - cpld = tx_cpld_req & tx_cpld_gnt.
  - mrdN = tx_mrdN_req & tx_mrd_gnt.
  - mwrN = tx_mwrN_req & tx_mwr_gnt.
- FSM states: IDLE, LAUNCH, BUSY.
  - IDLE: if any slot is eligible, register the winner and go to LAUNCH; else stay.
  - LAUNCH: assert eng_start and the winner's ack for exactly this cycle; assert eng_sel; go to BUSY.
  - BUSY: hold eng_sel; on eng_done, clear eng_sel and go to IDLE.
- Priority:
  - cpld wins over all other slots, unless cpld_run_cnt == CPLD_BURST_MAX and some non-cpld slot is eligible. In that case the round-robin winner is taken.
  - Round-robin covers 5 slots in order mrd0, mrd1, mrd2, mwr0, mwr1, with wrap-around. The search starts at the slot after the last round-robin winner; the pointer resets to mrd0.
  - The pointer updates only on a round-robin win.
- cpld_run_cnt (3 bits):
  - +1 on each cpld win, saturating at CPLD_BURST_MAX.
  - Cleared on any non-cpld win.
  - When saturated with no other slot eligible, cpld still wins and the count stays saturated.
- The decision is committed in IDLE. A grant or request dropping in LAUNCH does not cancel the launch.
- eng_done in IDLE or LAUNCH: ignored for state purposes; sets arb_proto_err.
- eng_done and a new request in the same BUSY cycle: the request is evaluated in the following IDLE cycle.
- Reset, including mid-BUSY, forces:
  - State IDLE, pointer mrd0, cpld_run_cnt 0.
  - All outputs 0: every ack, eng_sel, eng_start, arb_busy, arb_proto_err.

## Timing
- All outputs are registered.
- An eligible request sampled in IDLE at cycle T produces ack, eng_start and eng_sel at T+1. arb_busy is high from T+1.
- A requester deasserts its req at the edge after it sees the ack. Because BUSY lasts at least one cycle, the next IDLE never resamples a stale request.
- eng_done at cycle D (D ≥ T+2): eng_sel and arb_busy are 0 at D+1, and the state is IDLE at D+1.
- The earliest next launch is D+2, giving a back-to-back period of 3 cycles plus engine time.
- eng_sel is stable for the whole launch-to-done window.

## Structure
- Package pcie_tx_arb_pkg holds:
  - FSM state encoding.
  - Slot index constants: CPLD=0, MRD0=1, MRD1=2, MRD2=3, MWR0=4, MWR1=5.
  - Slot count constants: 6 total, 5 round-robin.
- Sub-module pcie_rr_pick5: purely combinational. It takes a 5-bit eligible mask and a 3-bit pointer, and returns a one-hot winner and the next pointer.
- The FSM, counter and ack/sel registers live in the top module.

## Test plan
- Reset, then tx_mrd0_req=1 with tx_mrd_gnt=1 → at the next cycle tx_mrd0_req_ack=1, eng_start=1, eng_sel=6'b000010; after eng_done, eng_sel=0.
- tx_cpld_req and tx_mwr1_req held continuously, all grants=1, CPLD_BURST_MAX=4 → launch order cpld, cpld, cpld, cpld, mwr1, cpld…
- mrd0, mrd1, mrd2, mwr0 and mwr1 all requesting and re-asserted after each ack → launch order mrd0, mrd1, mrd2, mwr0, mwr1, mrd0 (wrap).
- tx_mwr0_req=1 with tx_mwr_gnt=0, tx_mrd2_req=1 with tx_mrd_gnt=1 → only mrd2 is acked; mwr0 is acked only after tx_mwr_gnt rises.
- eng_done pulsed in IDLE → arb_proto_err=1 and stays 1 until pcie_user_rst.
- pcie_user_rst asserted during BUSY → all outputs 0 in the same cycle (asynchronous); after release, an mrd0 request wins first.

Source files
------------

// File: rtl/pcie_tx_req_arb_pkg.sv
// ----------------------------------------------------------------------------
// pcie_tx_arb_pkg
// Shared definitions for the PCIe TX request arbiter:
//   - arb_state_t : sequencer state encoding (IDLE -> LAUNCH -> BUSY)
//   - slot indices: CPLD=0, MRD0=1, MRD1=2, MRD2=3, MWR0=4, MWR1=5
//   - slot counts : NUM_SLOTS (all requesters), NUM_RR_SLOTS (round-robin set)
//   - rr_ptr_inc  : modulo-5 increment of a round-robin pointer
// ----------------------------------------------------------------------------
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } arb_state_t;

    localparam int CPLD = 0;
    localparam int MRD0 = 1;
    localparam int MRD1 = 2;
    localparam int MRD2 = 3;
    localparam int MWR0 = 4;
    localparam int MWR1 = 5;

    localparam int NUM_SLOTS    = 6;
    localparam int NUM_RR_SLOTS = 5;

    // Round-robin slot indices run 0..4 (mrd0..mwr1); wrap 4 -> 0.
    function automatic logic [2:0] rr_ptr_inc(input logic [2:0] p);
        return (p >= 3'(NUM_RR_SLOTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/pcie_tx_req_arb_if.sv
// ----------------------------------------------------------------------------
// pcie_tx_req_arb_if
// Bundles the requester-side and engine-side signals of the TX arbiter.
//   master : requesters / flow control / TX engine (drive req, gnt, eng_done)
//   slave  : the arbiter (drives acks, eng_sel, eng_start, arb_busy,
//            arb_proto_err)
// ----------------------------------------------------------------------------
interface pcie_tx_req_arb_if;
    import pcie_tx_arb_pkg::*;

    // flow-control grants per TLP class
    logic tx_cpld_gnt;
    logic tx_mrd_gnt;
    logic tx_mwr_gnt;

    // level requests, held until acked
    logic tx_cpld_req;
    logic tx_mrd0_req;
    logic tx_mrd1_req;
    logic tx_mrd2_req;
    logic tx_mwr0_req;
    logic tx_mwr1_req;

    // one-cycle ack pulses
    logic tx_cpld_req_ack;
    logic tx_mrd0_req_ack;
    logic tx_mrd1_req_ack;
    logic tx_mrd2_req_ack;
    logic tx_mwr0_req_ack;
    logic tx_mwr1_req_ack;

    // TX engine handshake and status
    logic [NUM_SLOTS-1:0] eng_sel;
    logic                 eng_start;
    logic                 eng_done;
    logic                 arb_busy;
    logic                 arb_proto_err;

    modport master (
        output tx_cpld_gnt, tx_mrd_gnt, tx_mwr_gnt,
        output tx_cpld_req, tx_mrd0_req, tx_mrd1_req, tx_mrd2_req,
               tx_mwr0_req, tx_mwr1_req,
        output eng_done,
        input  tx_cpld_req_ack, tx_mrd0_req_ack, tx_mrd1_req_ack,
               tx_mrd2_req_ack, tx_mwr0_req_ack, tx_mwr1_req_ack,
        input  eng_sel, eng_start, arb_busy, arb_proto_err
    );

    modport slave (
        input  tx_cpld_gnt, tx_mrd_gnt, tx_mwr_gnt,
        input  tx_cpld_req, tx_mrd0_req, tx_mrd1_req, tx_mrd2_req,
               tx_mwr0_req, tx_mwr1_req,
        input  eng_done,
        output tx_cpld_req_ack, tx_mrd0_req_ack, tx_mrd1_req_ack,
               tx_mrd2_req_ack, tx_mwr0_req_ack, tx_mwr1_req_ack,
        output eng_sel, eng_start, arb_busy, arb_proto_err
    );

endinterface

// File: rtl/pcie_tx_req_arb_rr_pick5.sv
// ----------------------------------------------------------------------------
// pcie_rr_pick5
// Combinational 5-way round-robin picker.
//   elig     in  5  eligible mask, bit i = round-robin slot i (mrd0..mwr1)
//   ptr      in  3  slot where the search starts (0..4)
//   win      out 5  one-hot winner (all zero when nothing is eligible)
//   ptr_next out 3  slot after the winner; equals ptr when nothing wins
// ----------------------------------------------------------------------------
module pcie_rr_pick5
    import pcie_tx_arb_pkg::*;
(
    input  logic [NUM_RR_SLOTS-1:0] elig,
    input  logic [2:0]              ptr,
    output logic [NUM_RR_SLOTS-1:0] win,
    output logic [2:0]              ptr_next
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        win      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        // An out-of-range pointer restarts the search at slot 0.
        idx      = (ptr > 3'(NUM_RR_SLOTS - 1)) ? 3'd0 : ptr;
        for (int k = 0; k < NUM_RR_SLOTS; k++) begin
            if (!found && elig[idx]) begin
                win[idx] = 1'b1;
                ptr_next = rr_ptr_inc(idx);
                found    = 1'b1;
            end
            idx = rr_ptr_inc(idx);
        end
    end

endmodule

// File: rtl/pcie_tx_req_arb.sv
// ----------------------------------------------------------------------------
// pcie_tx_req_arb
// Arbitrates the completion, three memory-read and two memory-write TX
// requests, qualified by their flow-control grants, and launches the shared
// TX TLP engine for one winner at a time.
//   pcie_user_clk  in   user clock, rising edge
//   pcie_user_rst  in   asynchronous active-high reset
//   bus            slave  requests/grants in, acks out, engine handshake
//                  (eng_sel one-hot {mwr1,mwr0,mrd2,mrd1,mrd0,cpld},
//                  eng_start, eng_done, arb_busy, sticky arb_proto_err)
// Completions have priority but are limited to CPLD_BURST_MAX consecutive
// wins while any memory request is eligible; the memory slots share a
// round-robin pointer.
// ----------------------------------------------------------------------------
module pcie_tx_req_arb
    import pcie_tx_arb_pkg::*;
#(
    parameter int CPLD_BURST_MAX = 4
) (
    input logic               pcie_user_clk,
    input logic               pcie_user_rst,
    pcie_tx_req_arb_if.slave  bus
);

    localparam logic [2:0] BURST_MAX = 3'(CPLD_BURST_MAX);

    arb_state_t               state;
    logic [2:0]               rr_ptr;
    logic [2:0]               cpld_run_cnt;
    logic [NUM_SLOTS-1:0]     sel_q;
    logic [NUM_SLOTS-1:0]     ack_q;
    logic                     start_q;
    logic                     busy_q;
    logic                     err_q;

    logic [NUM_SLOTS-1:0]     elig;
    logic [NUM_RR_SLOTS-1:0]  rr_win;
    logic [2:0]               rr_ptr_next;
    logic                     cpld_wins;
    logic [NUM_SLOTS-1:0]     win_sel;

    assign elig = {bus.tx_mwr1_req & bus.tx_mwr_gnt,
                   bus.tx_mwr0_req & bus.tx_mwr_gnt,
                   bus.tx_mrd2_req & bus.tx_mrd_gnt,
                   bus.tx_mrd1_req & bus.tx_mrd_gnt,
                   bus.tx_mrd0_req & bus.tx_mrd_gnt,
                   bus.tx_cpld_req & bus.tx_cpld_gnt};

    pcie_rr_pick5 u_rr (
        .elig     (elig[NUM_SLOTS-1:1]),
        .ptr      (rr_ptr),
        .win      (rr_win),
        .ptr_next (rr_ptr_next)
    );

    // A completion yields only once its burst budget is spent and a memory
    // slot is actually waiting; otherwise it keeps winning.
    assign cpld_wins = elig[CPLD] &&
                       !((cpld_run_cnt == BURST_MAX) && (|elig[NUM_SLOTS-1:1]));
    assign win_sel   = cpld_wins ? NUM_SLOTS'(1) : {rr_win, 1'b0};

    always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
        if (pcie_user_rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= 3'd0;
            cpld_run_cnt <= 3'd0;
            sel_q        <= '0;
            ack_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Engine completion is only legal once the launch has finished.
            if (bus.eng_done && (state != ST_BUSY)) begin
                err_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        sel_q   <= win_sel;
                        ack_q   <= win_sel;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ST_LAUNCH;
                        if (cpld_wins) begin
                            if (cpld_run_cnt != BURST_MAX) begin
                                cpld_run_cnt <= cpld_run_cnt + 3'd1;
                            end
                        end else begin
                            cpld_run_cnt <= 3'd0;
                            rr_ptr       <= rr_ptr_next;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // Decision is already committed; request/grant changes
                    // here have no effect.
                    ack_q   <= '0;
                    start_q <= 1'b0;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.eng_done) begin
                        sel_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.eng_sel         = sel_q;
    assign bus.eng_start       = start_q;
    assign bus.arb_busy        = busy_q;
    assign bus.arb_proto_err   = err_q;
    assign bus.tx_cpld_req_ack = ack_q[CPLD];
    assign bus.tx_mrd0_req_ack = ack_q[MRD0];
    assign bus.tx_mrd1_req_ack = ack_q[MRD1];
    assign bus.tx_mrd2_req_ack = ack_q[MRD2];
    assign bus.tx_mwr0_req_ack = ack_q[MWR0];
    assign bus.tx_mwr1_req_ack = ack_q[MWR1];

endmodule

// File: tb/tb_pcie_tx_req_arb.sv
// ----------------------------------------------------------------------------
// tb_pcie_tx_req_arb
// Randomised requesters/grants/engine around pcie_tx_req_arb, a behavioural
// reference model of the arbitration rules, a per-cycle output compare, and
// directed scenarios pinned with literal launch sequences.
// ----------------------------------------------------------------------------
module tb_pcie_tx_req_arb;

    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pcie_tx_req_arb_if bus ();

    pcie_tx_req_arb #(.CPLD_BURST_MAX(BURST)) dut (
        .pcie_user_clk (clk),
        .pcie_user_rst (rst),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus knobs (written by the main sequence only)
    logic [5:0] allow     = 6'b0;
    logic [2:0] gnt_set   = 3'b111;   // {mwr, mrd, cpld}
    bit         gnt_rand  = 1'b0;
    int         req_pct   = 0;
    int         done_pct  = 100;
    int         inject_req = 0;

    // launch log (written by the compare process only)
    int         log_slot[$];
    int         log_cyc[$];
    logic [5:0] log_ack[$];
    logic [5:0] log_sel[$];

    // reference model outputs
    logic [5:0] m_sel, m_ack;
    logic       m_start, m_busy, m_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] ack_vec();
        return {bus.tx_mwr1_req_ack, bus.tx_mwr0_req_ack, bus.tx_mrd2_req_ack,
                bus.tx_mrd1_req_ack, bus.tx_mrd0_req_ack, bus.tx_cpld_req_ack};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester / flow-control / engine driver
    initial begin
        logic [5:0] req_v;
        logic [2:0] gnt_v;
        logic [5:0] acks;
        int         inject_ack;
        req_v = '0; gnt_v = 3'b111; inject_ack = 0;
        bus.tx_cpld_req = 0; bus.tx_mrd0_req = 0; bus.tx_mrd1_req = 0;
        bus.tx_mrd2_req = 0; bus.tx_mwr0_req = 0; bus.tx_mwr1_req = 0;
        bus.tx_cpld_gnt = 1; bus.tx_mrd_gnt = 1; bus.tx_mwr_gnt = 1;
        bus.eng_done = 0;
        forever begin
            @(posedge clk);
            #1;
            acks = ack_vec();
            for (int i = 0; i < 6; i++) begin
                if (acks[3'(i)] || !allow[3'(i)])
                    req_v[3'(i)] = 1'b0;
                else if (!req_v[3'(i)] && ($urandom_range(0, 99) < 32'(req_pct)))
                    req_v[3'(i)] = 1'b1;
            end
            if (gnt_rand) begin
                if ($urandom_range(0, 9) == 0) gnt_v = 3'($urandom_range(0, 7));
            end else begin
                gnt_v = gnt_set;
            end
            if (bus.eng_done) begin
                bus.eng_done = 1'b0;
            end else if (inject_ack != inject_req) begin
                bus.eng_done = 1'b1;
                inject_ack = inject_req;
            end else if (bus.arb_busy && !bus.eng_start &&
                         ($urandom_range(0, 99) < 32'(done_pct))) begin
                bus.eng_done = 1'b1;
            end
            {bus.tx_mwr1_req, bus.tx_mwr0_req, bus.tx_mrd2_req,
             bus.tx_mrd1_req, bus.tx_mrd0_req, bus.tx_cpld_req} = req_v;
            {bus.tx_mwr_gnt, bus.tx_mrd_gnt, bus.tx_cpld_gnt} = gnt_v;
        end
    end

    // Reference model: decides launches from the arbitration rules using a
    // slot-index pointer and a run counter; outputs are expressed directly.
    initial begin
        logic [5:0] e;
        logic [2:0] s;
        int         win, ptr, run;
        bit         in_busy;
        m_sel = 0; m_ack = 0; m_start = 0; m_busy = 0; m_err = 0;
        ptr = 0; run = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_sel = 0; m_ack = 0; m_start = 0; m_busy = 0; m_err = 0;
                ptr = 0; run = 0;
            end else begin
                e = {bus.tx_mwr1_req & bus.tx_mwr_gnt, bus.tx_mwr0_req & bus.tx_mwr_gnt,
                     bus.tx_mrd2_req & bus.tx_mrd_gnt, bus.tx_mrd1_req & bus.tx_mrd_gnt,
                     bus.tx_mrd0_req & bus.tx_mrd_gnt, bus.tx_cpld_req & bus.tx_cpld_gnt};
                in_busy = m_busy && !m_start;
                if (bus.eng_done && !in_busy) m_err = 1'b1;
                if (m_start) begin
                    m_start = 0;
                    m_ack   = 0;
                end else if (m_busy) begin
                    if (bus.eng_done) begin
                        m_busy = 0;
                        m_sel  = 0;
                    end
                end else if (e != 0) begin
                    win = -1;
                    if (e[0] && !(run == BURST && e[5:1] != 0)) begin
                        win = 0;
                        if (run < BURST) run++;
                    end else begin
                        for (int k = 0; k < 5; k++) begin
                            s = 3'(1 + (ptr + k) % 5);
                            if (win < 0 && e[s]) win = int'(s);
                        end
                        ptr = win % 5;   // round-robin slot after the winner
                        run = 0;
                    end
                    m_sel   = 6'b1 << win;
                    m_ack   = m_sel;
                    m_start = 1;
                    m_busy  = 1;
                end
            end
        end
    end

    // Per-cycle compare and launch logging
    initial forever begin
        int slot;
        @(negedge clk);
        check("eng_sel",   32'(bus.eng_sel),       32'(m_sel));
        check("req_ack",   32'(ack_vec()),         32'(m_ack));
        check("eng_start", 32'(bus.eng_start),     32'(m_start));
        check("arb_busy",  32'(bus.arb_busy),      32'(m_busy));
        check("proto_err", 32'(bus.arb_proto_err), 32'(m_err));
        if (bus.eng_start === 1'b1) begin
            slot = 7;
            if ($onehot(bus.eng_sel))
                for (int i = 0; i < 6; i++) if (bus.eng_sel[3'(i)]) slot = i;
            log_slot.push_back(slot);
            log_cyc.push_back(cyc);
            log_ack.push_back(ack_vec());
            log_sel.push_back(bus.eng_sel);
        end
    end

    task automatic clear_log();
        log_slot.delete(); log_cyc.delete(); log_ack.delete(); log_sel.delete();
    endtask

    task automatic settle();
        allow    = 6'b0;
        done_pct = 100;
        gnt_rand = 1'b0;
        repeat (10) @(negedge clk);
        clear_log();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (log_slot.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check({"launch_count_", tag}, 32'(log_slot.size() >= n), 32'd1);
    endtask

    task automatic check_order(input string tag, input int exp[6]);
        for (int i = 0; i < 6; i++)
            if (i < log_slot.size())
                check($sformatf("%s_%0d", tag, i), 32'(log_slot[i]), 32'(exp[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int exp_burst[6] = '{0, 0, 0, 0, 5, 0};
        int exp_rr[6]    = '{1, 2, 3, 4, 5, 1};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_sel",   32'(bus.eng_sel), 32'd0);
        check("rst_ack",   32'(ack_vec()),   32'd0);
        check("rst_start", 32'(bus.eng_start), 32'd0);
        check("rst_busy",  32'(bus.arb_busy),  32'd0);
        check("rst_err",   32'(bus.arb_proto_err), 32'd0);
        rst = 1'b0;
        settle();

        // single mrd0 request: latency, ack, sel, back-to-back spacing
        gnt_set = 3'b111; req_pct = 100; done_pct = 100;
        t0 = cyc;
        allow = 6'b000010;
        wait_log(2, 50, "mrd0");
        if (log_slot.size() >= 2) begin
            check("mrd0_latency", 32'(log_cyc[0] - t0), 32'd2);
            check("mrd0_ack",     32'(log_ack[0]), 32'b000010);
            check("mrd0_sel",     32'(log_sel[0]), 32'b000010);
            check("mrd0_period",  32'(log_cyc[1] - log_cyc[0]), 32'd3);
        end
        settle();
        check("idle_sel", 32'(bus.eng_sel), 32'd0);

        // completion burst limit
        req_pct = 100;
        allow = 6'b100001;
        wait_log(6, 200, "burst");
        check_order("burst", exp_burst);
        settle();

        // round-robin order with wrap
        pulse_reset();
        req_pct = 100;
        allow = 6'b111110;
        wait_log(6, 200, "rr");
        check_order("rr", exp_rr);
        settle();

        // grant qualification: mwr0 waits for its grant
        gnt_set = 3'b011; req_pct = 100;
        allow = 6'b011000;
        wait_log(1, 50, "gnt_a");
        allow = 6'b010000;
        repeat (12) @(negedge clk);
        check("gnt_only_one", 32'(log_slot.size()), 32'd1);
        if (log_slot.size() >= 1) check("gnt_first", 32'(log_slot[0]), 32'd3);
        gnt_set = 3'b111;
        wait_log(2, 50, "gnt_b");
        if (log_slot.size() >= 2) check("gnt_second", 32'(log_slot[1]), 32'd4);
        settle();

        // eng_done in IDLE sets the sticky error
        check("err_before", 32'(bus.arb_proto_err), 32'd0);
        inject_req++;
        repeat (3) @(negedge clk);
        check("err_set", 32'(bus.arb_proto_err), 32'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(bus.arb_proto_err), 32'd1);
        pulse_reset();
        check("err_cleared", 32'(bus.arb_proto_err), 32'd0);
        settle();

        // asynchronous reset during BUSY, then pointer restarts at mrd0
        gnt_set = 3'b111; req_pct = 100; done_pct = 0;
        allow = 6'b000010;
        wait_log(1, 50, "rb_launch");
        allow = 6'b0;
        repeat (2) @(negedge clk);
        check("rb_busy_before", 32'(bus.arb_busy), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rb_sel",   32'(bus.eng_sel),   32'd0);
        check("rb_ack",   32'(ack_vec()),     32'd0);
        check("rb_start", 32'(bus.eng_start), 32'd0);
        check("rb_busy",  32'(bus.arb_busy),  32'd0);
        check("rb_err",   32'(bus.arb_proto_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        done_pct = 100;
        allow = 6'b000110;
        wait_log(1, 50, "rb_after");
        if (log_slot.size() >= 1) check("rb_first_winner", 32'(log_slot[0]), 32'd1);
        settle();

        // randomised traffic against the model
        gnt_rand = 1'b1; req_pct = 35; done_pct = 45;
        allow = 6'b111111;
        repeat (3000) @(negedge clk);
        check("rand_launched", 32'(log_slot.size() > 100), 32'd1);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
